// File: rtl/icache_direct_if.sv
`timescale 1ns/1ps
// Fetch-side and memory-side signal bundle for the direct-mapped instruction cache.
// slave: cache view (fetch request, flush and memory return in; instruction and memory request out).
// master: environment view (fetcher + memory controller), directions mirrored.
interface icache_direct_if #(
  parameter int ADDR_W = 32
);
  logic              fetch_en;
  logic [ADDR_W-1:0] pc_in;
  logic              flush;
  logic              instr_valid;
  logic [31:0]       instr_out;
  logic              mc_req;
  logic [ADDR_W-1:0] mc_addr;
  logic              mc_done;
  logic [31:0]       mc_data;

  modport slave (
    input  fetch_en, pc_in, flush, mc_done, mc_data,
    output instr_valid, instr_out, mc_req, mc_addr
  );

  modport master (
    output fetch_en, pc_in, flush, mc_done, mc_data,
    input  instr_valid, instr_out, mc_req, mc_addr
  );
endinterface

// File: rtl/icache_direct.sv
`timescale 1ns/1ps
// Direct-mapped, one-word-per-line instruction cache in front of the fetcher.
// Latency: hit 1 cycle; miss = memory latency + 1 (instruction returned on the mc_done edge).
// Backpressure: rdy=0 freezes every register; fetch_en/pc_in are only sampled in IDLE.
// Ports: clk, rst_n (async active-low), rdy (global pause), bus (icache_direct_if.slave):
//   fetch_en/pc_in/flush from the fetcher, instr_valid/instr_out back to it,
//   mc_req/mc_addr to the memory controller, mc_done/mc_data from it.
module icache_direct #(
  parameter int IDX_W  = 8,
  parameter int ADDR_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rdy,
  icache_direct_if.slave bus
);
  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {IDLE, MISS, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [LINES-1:0]  line_vld;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [LINES];

  logic              vld_nxt;
  logic [31:0]       out_nxt;
  logic              req_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              fill_en;

  logic [IDX_W-1:0]  req_idx, fill_idx;
  logic [TAG_W-1:0]  req_tag, fill_tag;
  logic              hit;
  logic              unused_bits;

  assign req_idx  = bus.pc_in[IDX_W+1:2];
  assign req_tag  = bus.pc_in[ADDR_W-1:IDX_W+2];
  // mc_addr doubles as the latched miss address for the whole MISS/DRAIN window.
  assign fill_idx = bus.mc_addr[IDX_W+1:2];
  assign fill_tag = bus.mc_addr[ADDR_W-1:IDX_W+2];
  assign hit      = line_vld[req_idx] && (tag_mem[req_idx] == req_tag);

  // Byte-offset bits carry no information for word fetches.
  assign unused_bits = ^{bus.pc_in[1:0], bus.mc_addr[1:0]};

  always_comb begin
    state_nxt = state;
    vld_nxt   = 1'b0;
    out_nxt   = bus.instr_out;
    req_nxt   = bus.mc_req;
    addr_nxt  = bus.mc_addr;
    fill_en   = 1'b0;
    unique case (state)
      IDLE: begin
        // flush wins over a same-cycle request; stray mc_done is ignored here.
        if (!bus.flush && bus.fetch_en) begin
          if (hit) begin
            vld_nxt = 1'b1;
            out_nxt = data_mem[req_idx];
          end else begin
            req_nxt   = 1'b1;
            addr_nxt  = {bus.pc_in[ADDR_W-1:2], 2'b00};
            state_nxt = MISS;
          end
        end
      end
      MISS: begin
        if (bus.mc_done) begin
          // The returned word is correct for mc_addr, so fill even when flushed.
          fill_en   = 1'b1;
          req_nxt   = 1'b0;
          state_nxt = IDLE;
          if (!bus.flush) begin
            vld_nxt = 1'b1;
            out_nxt = bus.mc_data;
          end
        end else if (bus.flush) begin
          req_nxt   = 1'b0;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Memory still owes one response for the abandoned request.
        req_nxt = 1'b0;
        if (bus.mc_done) begin
          fill_en   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      line_vld        <= '0;
      bus.instr_valid <= 1'b0;
      bus.instr_out   <= '0;
      bus.mc_req      <= 1'b0;
      bus.mc_addr     <= '0;
    end else if (rdy) begin
      state           <= state_nxt;
      bus.instr_valid <= vld_nxt;
      bus.instr_out   <= out_nxt;
      bus.mc_req      <= req_nxt;
      bus.mc_addr     <= addr_nxt;
      if (fill_en) begin
        line_vld[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag/data arrays are qualified by line_vld, so they need no reset.
  always_ff @(posedge clk) begin
    if (rdy && fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= bus.mc_data;
    end
  end
endmodule

// File: tb/tb_icache_direct.sv
`timescale 1ns/1ps
// Directed bench for icache_direct: expected instructions are queued when a
// request/response is driven and popped when instr_valid pulses.
module tb_icache_direct;
  logic clk;
  logic rst_n;
  logic rdy;

  icache_direct_if #(.ADDR_W(32)) bus ();

  icache_direct #(.IDX_W(8), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned pulses = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mem [logic [31:0]];
  logic        last_rdy = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory controller returns the word for addr on the next edge.
  task automatic deliver(input logic [31:0] addr, input bit expect_pulse);
    bus.mc_done = 1'b1;
    bus.mc_data = mem[addr];
    if (expect_pulse) exp_q.push_back(mem[addr]);
    step();
    bus.mc_done = 1'b0;
    bus.mc_data = 32'hDEAD_BEEF;
  endtask

  always @(posedge clk) last_rdy <= rdy;

  // Scoreboard consumer: every real pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && last_rdy && bus.instr_valid) begin
      pulses++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_pulse: observed instr=%h expected no pulse", bus.instr_out);
      end
      if (exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++;
        assert (bus.instr_out === e) else begin
          errors++;
          $error("FAIL instr_out: observed=%h expected=%h", bus.instr_out, e);
        end
      end
    end
  end

  initial begin
    int unsigned p0;
    mem[32'h0000_0004] = 32'h0050_0093;
    mem[32'h0000_0404] = 32'h00A0_0113;
    mem[32'h0000_0010] = 32'h00C0_0193;
    mem[32'h0000_0020] = 32'h0010_0213;
    mem[32'h0000_0030] = 32'h0020_0293;

    rst_n = 1'b0; rdy = 1'b1;
    bus.fetch_en = 1'b0; bus.pc_in = '0; bus.flush = 1'b0;
    bus.mc_done = 1'b0; bus.mc_data = '0;

    // Reset state
    step(); step();
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr_out", bus.instr_out, 32'd0);
    chk("rst_mc_req", 32'(bus.mc_req), 32'd0);
    chk("rst_mc_addr", bus.mc_addr, 32'd0);
    rst_n = 1'b1;
    step();

    // Cold miss on 0x4, memory answers 3 cycles after the request
    p0 = pulses;
    bus.fetch_en = 1'b1; bus.pc_in = 32'h4;
    step();
    bus.fetch_en = 1'b0;
    chk("cold_req", 32'(bus.mc_req), 32'd1);
    chk("cold_addr", bus.mc_addr, 32'h4);
    step();
    chk("cold_req_hold1", 32'(bus.mc_req), 32'd1);
    step();
    chk("cold_addr_hold2", bus.mc_addr, 32'h4);
    deliver(32'h4, 1'b1);
    chk("cold_valid", 32'(bus.instr_valid), 32'd1);
    chk("cold_data", bus.instr_out, 32'h0050_0093);
    step();
    chk("cold_valid_drop", 32'(bus.instr_valid), 32'd0);
    chk("cold_req_drop", 32'(bus.mc_req), 32'd0);
    chk("cold_one_pulse", pulses - p0, 32'd1);

    // Back-to-back hits on 0x4
    p0 = pulses;
    bus.fetch_en = 1'b1; bus.pc_in = 32'h4;
    exp_q.push_back(32'h0050_0093);
    step();
    chk("hit1_valid", 32'(bus.instr_valid), 32'd1);
    chk("hit1_no_req", 32'(bus.mc_req), 32'd0);
    exp_q.push_back(32'h0050_0093);
    step();
    bus.fetch_en = 1'b0;
    chk("hit2_valid", 32'(bus.instr_valid), 32'd1);
    step();
    chk("hit_idle", 32'(bus.instr_valid), 32'd0);
    chk("hit_two_pulses", pulses - p0, 32'd2);

    // Conflict: 0x404 shares index 1 with 0x4
    bus.fetch_en = 1'b1; bus.pc_in = 32'h404;
    step();
    bus.fetch_en = 1'b0;
    chk("conf_req", 32'(bus.mc_req), 32'd1);
    chk("conf_addr", bus.mc_addr, 32'h404);
    step();
    deliver(32'h404, 1'b1);
    chk("conf_data", bus.instr_out, 32'h00A0_0113);
    bus.fetch_en = 1'b1; bus.pc_in = 32'h4;
    step();
    bus.fetch_en = 1'b0;
    chk("evict_req", 32'(bus.mc_req), 32'd1);
    chk("evict_addr", bus.mc_addr, 32'h4);
    chk("evict_no_valid", 32'(bus.instr_valid), 32'd0);
    deliver(32'h4, 1'b1);
    step();

    // Flush mid-miss on 0x10, requests ignored while draining
    p0 = pulses;
    bus.fetch_en = 1'b1; bus.pc_in = 32'h10;
    step();
    chk("fl_req", 32'(bus.mc_req), 32'd1);
    bus.fetch_en = 1'b0; bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("fl_req_drop", 32'(bus.mc_req), 32'd0);
    bus.fetch_en = 1'b1; bus.pc_in = 32'h20;
    step();
    chk("drain_ignores_req", 32'(bus.mc_req), 32'd0);
    step();
    bus.fetch_en = 1'b0;
    bus.pc_in = 32'h10;
    deliver(32'h10, 1'b0);
    chk("drain_no_valid", 32'(bus.instr_valid), 32'd0);
    chk("drain_no_pulse", pulses - p0, 32'd0);
    bus.fetch_en = 1'b1; bus.pc_in = 32'h10;
    exp_q.push_back(32'h00C0_0193);
    step();
    bus.fetch_en = 1'b0;
    chk("fl_refetch_hit", 32'(bus.instr_valid), 32'd1);
    chk("fl_refetch_no_req", 32'(bus.mc_req), 32'd0);
    step();

    // Flush against a hit on the same edge
    bus.fetch_en = 1'b1; bus.pc_in = 32'h4; bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flhit_no_valid", 32'(bus.instr_valid), 32'd0);
    chk("flhit_no_req", 32'(bus.mc_req), 32'd0);
    exp_q.push_back(32'h0050_0093);
    step();
    bus.fetch_en = 1'b0;
    chk("flhit_next_ok", 32'(bus.instr_valid), 32'd1);
    step();

    // Flush together with mc_done: line filled, no pulse
    bus.fetch_en = 1'b1; bus.pc_in = 32'h20;
    step();
    bus.fetch_en = 1'b0;
    bus.flush = 1'b1;
    deliver(32'h20, 1'b0);
    bus.flush = 1'b0;
    chk("fldone_no_valid", 32'(bus.instr_valid), 32'd0);
    chk("fldone_req_drop", 32'(bus.mc_req), 32'd0);
    bus.fetch_en = 1'b1;
    exp_q.push_back(32'h0010_0213);
    step();
    bus.fetch_en = 1'b0;
    chk("fldone_hit", 32'(bus.instr_valid), 32'd1);
    step();

    // Pause for 4 cycles during a miss on 0x404
    bus.fetch_en = 1'b1; bus.pc_in = 32'h404;
    step();
    bus.fetch_en = 1'b0;
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("pause_req", 32'(bus.mc_req), 32'd1);
      chk("pause_addr", bus.mc_addr, 32'h404);
    end
    rdy = 1'b1;
    step();
    chk("resume_req", 32'(bus.mc_req), 32'd1);
    deliver(32'h404, 1'b1);
    chk("resume_valid", 32'(bus.instr_valid), 32'd1);
    step();

    // Async reset mid-miss
    bus.fetch_en = 1'b1; bus.pc_in = 32'h30;
    step();
    bus.fetch_en = 1'b0;
    chk("rst_pre_req", 32'(bus.mc_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(bus.mc_req), 32'd0);
    chk("arst_valid", 32'(bus.instr_valid), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    bus.fetch_en = 1'b1; bus.pc_in = 32'h4;
    step();
    bus.fetch_en = 1'b0;
    chk("post_rst_miss", 32'(bus.mc_req), 32'd1);
    chk("post_rst_no_valid", 32'(bus.instr_valid), 32'd0);
    step();
    deliver(32'h4, 1'b1);
    step();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, word-granular instruction cache directly upstream of the instruction fetcher.
- Accepts a fetch PC when the fetcher is ready and returns a 32-bit instruction with a one-cycle valid pulse.
- On a miss, fetches the word from the memory controller, fills the line, then returns it.
- Supports a flush from roll-back that abandons any in-flight fetch.

Parameters:
IDX_W, 8, index bits; cache holds 2^IDX_W one-word lines (256 default)
ADDR_W, 32, PC/address width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
rdy  in  1  global ready; low = pause, all state frozen
fetch_en  in  1  fetcher can accept an instruction (driven from rdy_2icache)
pc_in  in  ADDR_W  fetch address, word aligned
flush  in  1  mispredict roll-back; discard pending fetch
instr_valid  out  1  one-cycle pulse: instr_out valid for last accepted pc_in
instr_out  out  32  fetched instruction
mc_req  out  1  word read request to memory controller
mc_addr  out  ADDR_W  request address
mc_done  in  1  one-cycle pulse: mc_data valid
mc_data  in  32  word returned by memory controller

Behaviour:
- Reset (rst_n=0, async):
  - all line valid bits 0; state IDLE.
  - instr_valid=0, instr_out=0, mc_req=0, mc_addr=0.
  - Tag/data arrays need no reset.
- Address split:
  - index = pc_in[IDX_W+1:2]; tag = pc_in[ADDR_W-1:IDX_W+2].
  - pc_in[1:0] ignored.
- rdy=0: no register changes; outputs hold their values, including instr_valid. Fetcher also freezes, so no double consume.
- All actions below apply only on edges with rdy=1.
- instr_valid defaults to 0 every cycle unless set as below (strictly a single-cycle pulse).
- States: IDLE, MISS, DRAIN.
- IDLE, fetch_en=1, flush=0:
  - Hit (valid & tag match): next edge instr_valid=1, instr_out=data[index]. Hit latency 1 cycle. Stay IDLE; a new request may be accepted the next cycle (back-to-back hits give one instruction per cycle).
  - Miss: latch pc_in; mc_req=1, mc_addr={pc[ADDR_W-1:2],2'b00}; go MISS.
- MISS:
  - mc_req and mc_addr held stable until mc_done.
  - On mc_done (flush=0): write data, tag and valid=1 at latched index; instr_valid=1, instr_out=mc_data on the same edge; mc_req=0; go IDLE.
  - Miss latency = memory latency + 1 cycle after request.
  - fetch_en and pc_in are ignored outside IDLE; the fetcher keeps its pc until instr_valid.
- flush (priority over everything, rdy=1):
  - IDLE: pending hit pulse suppressed (instr_valid=0 next cycle); fetch_en on the same cycle is ignored.
  - MISS without mc_done: mc_req=0; go DRAIN.
  - MISS with mc_done on the same edge: line is filled, instr_valid=0, go IDLE.
- DRAIN:
  - mc_req=0; wait for the outstanding mc_done.
  - On mc_done: fill the line (data is correct for that address), no instr_valid, go IDLE.
  - Requests are ignored until then.
  - Memory controller guarantees exactly one mc_done per accepted request even if mc_req drops.
- mc_done arriving in IDLE is ignored (protocol error, no state change).
- Replacement: direct-mapped; a fill overwrites the line unconditionally.
- Cache is never invalidated except by reset (no self-modifying code).

Test Plan:
- Reset then cold miss: pc_in=0x00000004, fetch_en=1; memory returns 0x00500093 after 3 cycles -> mc_req=1 with mc_addr=0x00000004 until mc_done; instr_valid=1 with instr_out=0x00500093 on the mc_done edge; exactly one pulse.
- Hit after fill: pc_in=0x00000004 again -> instr_valid=1, instr_out=0x00500093 one cycle later; mc_req stays 0. Back-to-back hits on 0x4,0x4 -> two consecutive pulses.
- Conflict eviction:
  - Fetch 0x00000404 (index 1, tag 1), memory returns 0x00A00113 -> miss, fill.
  - Refetch 0x00000004 -> miss again (tag 0 evicted), mc_addr=0x00000004.
- Flush mid-miss: miss on 0x00000010, assert flush one cycle after mc_req rises -> mc_req=0 next cycle; state DRAIN; mc_done later gives no instr_valid; refetch 0x10 is a hit with the returned data.
- Flush vs hit: hit request and flush on the same edge -> no instr_valid; next fetch accepted normally.
- Pause and reset:
  - Drop rdy for 4 cycles during MISS while mc_done is low -> mc_req/mc_addr/state unchanged; completes normally after rdy returns.
  - Assert rst_n=0 asynchronously mid-MISS -> mc_req=0 and instr_valid=0 immediately; all lines invalid afterwards (fetch of 0x4 misses).
